// File: rtl/tap_step_pkg.sv
// rtl/tap_step_pkg.sv - shared opcodes and controller state type for the tap-step ranger
package tap_step_pkg;

    localparam logic [3:0] OPC_TAP_MAX  = 4'd6;
    localparam logic [3:0] OPC_TAP_SET  = 4'd7;
    localparam logic [3:0] OPC_TAP_AUTO = 4'd8;

    typedef enum logic {
        MONITOR = 1'b0,
        SETTLE  = 1'b1
    } tapState_e;

endpackage

// File: rtl/tap_edge_sync.sv
// rtl/tap_edge_sync.sv - two-stage input register with rising-edge detect
//   clk       in   system clock
//   rest      in   asynchronous active-low reset
//   din       in   raw input level
//   level     out  second-stage registered level
//   riseNow   out  combinational rising edge between the two stages
//   risePulse out  riseNow delayed by one register (one cycle per rising edge)
module tap_edge_sync (
    input  logic clk,
    input  logic rest,
    input  logic din,
    output logic level,
    output logic riseNow,
    output logic risePulse
);

    logic syncQ1;
    logic syncQ2;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            syncQ1    <= 1'b0;
            syncQ2    <= 1'b0;
            risePulse <= 1'b0;
        end else begin
            syncQ1    <= din;
            syncQ2    <= syncQ1;
            risePulse <= syncQ1 & ~syncQ2;
        end
    end

    assign level   = syncQ2;
    assign riseNow = syncQ1 & ~syncQ2;

endmodule

// File: rtl/tap_step_ranger.sv
// rtl/tap_step_ranger.sv - clamped multi-level tap-step controller with settle window
//   Optional feature macro: TAP_AUTO_RANGE_EN (opcode 8, autoMode, under-range up-stepping)
//   clk             in   system clock
//   rest            in   asynchronous active-low reset
//   inputCmd        in   command word, [31:28] opcode, [STEP_W-1:0] argument
//   inputCmdTrigger in   command strobe, rising edge executes inputCmd
//   overDec         in   over-range flag
//   underDec        in   under-range flag (auto-range builds only)
//   tapStep         out  current tap-step code
//   stepChanged     out  one-cycle pulse on every tapStep change
//   stepBusy        out  high during the post-change settle window
module tap_step_ranger #(
    parameter int STEP_W     = 4,
    parameter int STEP_MIN   = 5,
    parameter int STEP_MAX   = 10,
    parameter int SETTLE_CYC = 1024,
    parameter int UNDER_HOLD = 4096
) (
    input  logic              clk,
    input  logic              rest,
    input  logic [31:0]       inputCmd,
    input  logic              inputCmdTrigger,
    input  logic              overDec,
    input  logic              underDec,
    output logic [STEP_W-1:0] tapStep,
    output logic              stepChanged,
    output logic              stepBusy
);

    import tap_step_pkg::*;

    localparam int EXT_W   = STEP_W + 1;
    localparam int CNT_MAX = (SETTLE_CYC > UNDER_HOLD) ? SETTLE_CYC : UNDER_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [STEP_W-1:0] CODE_MIN    = STEP_W'(STEP_MIN);
    localparam logic [STEP_W-1:0] CODE_MAX    = STEP_W'(STEP_MAX);
    localparam logic [EXT_W-1:0]  EXT_MIN     = EXT_W'(STEP_MIN);
    localparam logic [EXT_W-1:0]  EXT_MAX     = EXT_W'(STEP_MAX);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    // Widened arithmetic result forced back into the legal code range.
    function automatic logic [STEP_W-1:0] clampCode(input logic [EXT_W-1:0] v);
        if (v < EXT_MIN) begin
            return CODE_MIN;
        end else if (v > EXT_MAX) begin
            return CODE_MAX;
        end else begin
            return v[STEP_W-1:0];
        end
    endfunction

    logic trigLevel, trigRiseNow, cmdPulse;
    logic overLevel, overRiseNow, overPulse;
    logic underLevel, underRiseNow, underPulse;

    tap_edge_sync trigSync (
        .clk       (clk),
        .rest      (rest),
        .din       (inputCmdTrigger),
        .level     (trigLevel),
        .riseNow   (trigRiseNow),
        .risePulse (cmdPulse)
    );

    tap_edge_sync overSync (
        .clk       (clk),
        .rest      (rest),
        .din       (overDec),
        .level     (overLevel),
        .riseNow   (overRiseNow),
        .risePulse (overPulse)
    );

    tap_edge_sync underSync (
        .clk       (clk),
        .rest      (rest),
        .din       (underDec),
        .level     (underLevel),
        .riseNow   (underRiseNow),
        .risePulse (underPulse)
    );

    // Command word rides alongside the first trigger stage; it is frozen on
    // the detected edge so it lines up with the delayed cmdPulse.
    logic [3:0]        cmdOpcQ, cmdOpcHeld;
    logic [STEP_W-1:0] cmdArgQ, cmdArgHeld;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            cmdOpcQ    <= '0;
            cmdArgQ    <= '0;
            cmdOpcHeld <= '0;
            cmdArgHeld <= '0;
        end else begin
            cmdOpcQ <= inputCmd[31:28];
            cmdArgQ <= inputCmd[STEP_W-1:0];
            if (trigRiseNow) begin
                cmdOpcHeld <= cmdOpcQ;
                cmdArgHeld <= cmdArgQ;
            end
        end
    end

    tapState_e         state, stateNxt;
    logic [STEP_W-1:0] tapNxt;
    logic              changedNxt;
    logic [CNT_W-1:0]  settleCnt, settleNxt;
    logic              reqValid;
    logic [STEP_W-1:0] reqCode;

`ifdef TAP_AUTO_RANGE_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(UNDER_HOLD - 1);

    logic             autoMode, autoNxt;
    logic [CNT_W-1:0] holdCnt, holdNxt;
    logic [EXT_W-1:0] tapExt;

    assign tapExt = {1'b0, tapStep};
`endif

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state       <= MONITOR;
            tapStep     <= CODE_MIN;
            stepChanged <= 1'b0;
            settleCnt   <= '0;
`ifdef TAP_AUTO_RANGE_EN
            autoMode    <= 1'b0;
            holdCnt     <= '0;
`endif
        end else begin
            state       <= stateNxt;
            tapStep     <= tapNxt;
            stepChanged <= changedNxt;
            settleCnt   <= settleNxt;
`ifdef TAP_AUTO_RANGE_EN
            autoMode    <= autoNxt;
            holdCnt     <= holdNxt;
`endif
        end
    end

    always_comb begin
        stateNxt   = state;
        tapNxt     = tapStep;
        changedNxt = 1'b0;
        settleNxt  = settleCnt;
        reqValid   = 1'b0;
        reqCode    = tapStep;
`ifdef TAP_AUTO_RANGE_EN
        autoNxt    = autoMode;
        holdNxt    = holdCnt;
`endif

        // Request arbitration: command beats over-range beats under-range.
        if (cmdPulse) begin
            case (cmdOpcHeld)
                OPC_TAP_MAX: begin
                    reqValid = 1'b1;
                    reqCode  = CODE_MAX;
                end
                OPC_TAP_SET: begin
                    reqValid = 1'b1;
                    reqCode  = clampCode({1'b0, cmdArgHeld});
                end
                OPC_TAP_AUTO: begin
`ifdef TAP_AUTO_RANGE_EN
                    autoNxt = cmdArgHeld[0];
`endif
                end
                default: begin
                end
            endcase
        end else if (state == MONITOR && overPulse) begin
            reqValid = 1'b1;
`ifdef TAP_AUTO_RANGE_EN
            if (autoMode) begin
                reqCode = clampCode((tapExt == '0) ? '0 : tapExt - 1'b1);
            end else begin
                reqCode = CODE_MIN;
            end
`else
            reqCode = CODE_MIN;
`endif
        end
`ifdef TAP_AUTO_RANGE_EN
        else if (state == MONITOR && autoMode && underLevel && holdCnt == HOLD_LAST) begin
            reqValid = 1'b1;
            reqCode  = clampCode(tapExt + 1'b1);
        end

        // Hold count restarts on every low sample, on reaching the limit,
        // and whenever under-range events are not being accepted.
        if (state != MONITOR || !autoMode || !underLevel || holdCnt == HOLD_LAST) begin
            holdNxt = '0;
        end else begin
            holdNxt = holdCnt + 1'b1;
        end
`endif

        if (state == SETTLE) begin
            if (settleCnt == SETTLE_LAST) begin
                stateNxt  = MONITOR;
                settleNxt = '0;
            end else begin
                settleNxt = settleCnt + 1'b1;
            end
        end

        // Only a real change of code pulses stepChanged and (re)opens the window.
        if (reqValid && reqCode != tapStep) begin
            tapNxt     = reqCode;
            changedNxt = 1'b1;
            stateNxt   = SETTLE;
            settleNxt  = '0;
`ifdef TAP_AUTO_RANGE_EN
            holdNxt    = '0;
`endif
        end
    end

    assign stepBusy = (state == SETTLE);

    logic unusedSignals;
`ifdef TAP_AUTO_RANGE_EN
    assign unusedSignals = ^{inputCmd[27:STEP_W], trigLevel, overLevel, overRiseNow,
                             underRiseNow, underPulse};
`else
    assign unusedSignals = ^{inputCmd[27:STEP_W], trigLevel, overLevel, overRiseNow,
                             underLevel, underRiseNow, underPulse};
`endif

endmodule

// File: tb/tb_tap_step_ranger.sv
// tb/tb_tap_step_ranger.sv - directed self-checking bench for tap_step_ranger
module tb_tap_step_ranger;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] inputCmd;
    logic        inputCmdTrigger;
    logic        overDec;
    logic        underDec;
    logic [3:0]  tapStep;
    logic        stepChanged;
    logic        stepBusy;

    int compared   = 0;
    int mismatched = 0;

    tap_step_ranger dut (
        .clk             (clk),
        .rest            (rest),
        .inputCmd        (inputCmd),
        .inputCmdTrigger (inputCmdTrigger),
        .overDec         (overDec),
        .underDec        (underDec),
        .tapStep         (tapStep),
        .stepChanged     (stepChanged),
        .stepBusy        (stepBusy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Strobe one command; returns two negedges after the strobe, i.e. just
    // after the edge on which tapStep reacts.
    task automatic issueCmd(input logic [3:0] opc, input logic [3:0] arg);
        inputCmd        = {opc, 24'h5A5A00, arg};
        inputCmdTrigger = 1'b1;
        tick(1);
        inputCmdTrigger = 1'b0;
        tick(2);
    endtask

    task automatic overPulse();
        overDec = 1'b1;
        tick(1);
        overDec = 1'b0;
        tick(2);
    endtask

    initial begin
        rest            = 1'b0;
        inputCmd        = '0;
        inputCmdTrigger = 1'b0;
        overDec         = 1'b0;
        underDec        = 1'b0;
        tick(3);
        check("reset_tap", tapStep, 5);
        check("reset_changed", stepChanged, 0);
        check("reset_busy", stepBusy, 0);
        rest = 1'b1;
        tick(2);

        // opcode 6: latency, single pulse, settle window length
        inputCmd        = {4'd6, 28'h0};
        inputCmdTrigger = 1'b1;
        tick(1);
        inputCmdTrigger = 1'b0;
        tick(1);
        check("max_before_k2", tapStep, 5);
        check("max_changed_before", stepChanged, 0);
        tick(1);
        check("max_tap", tapStep, 10);
        check("max_changed", stepChanged, 1);
        check("max_busy_rise", stepBusy, 1);
        tick(1);
        check("max_changed_one_cycle", stepChanged, 0);
        tick(1022);
        check("max_busy_last", stepBusy, 1);
        tick(1);
        check("max_busy_fall", stepBusy, 0);

        // opcode 7 clamping and no-op
        issueCmd(4'd7, 4'd3);
        check("set3_clamp", tapStep, 5);
        check("set3_changed", stepChanged, 1);
        tick(1100);
        issueCmd(4'd7, 4'd12);
        check("set12_clamp", tapStep, 10);
        tick(1100);
        issueCmd(4'd7, 4'd10);
        check("set10_tap", tapStep, 10);
        check("set10_no_pulse", stepChanged, 0);
        check("set10_no_settle", stepBusy, 0);

        // held trigger executes only once
        inputCmd        = {4'd7, 24'h0, 4'd7};
        inputCmdTrigger = 1'b1;
        tick(3);
        check("held_first", tapStep, 7);
        inputCmd = {4'd7, 24'h0, 4'd9};
        tick(5);
        check("held_once", tapStep, 7);
        inputCmdTrigger = 1'b0;
        tick(1100);

        // over-range with autoMode 0, command restarting settle, over ignored in settle
        issueCmd(4'd6, 4'd0);
        check("pre_over_tap", tapStep, 10);
        tick(1100);
        overPulse();
        check("over_min", tapStep, 5);
        check("over_changed", stepChanged, 1);
        tick(10);
        issueCmd(4'd6, 4'd0);
        check("cmd_in_settle", tapStep, 10);
        tick(5);
        overPulse();
        check("over_in_settle_ignored", tapStep, 10);
        tick(1010);
        check("settle_restarted", stepBusy, 1);
        tick(6);
        check("settle_restart_end", stepBusy, 0);

`ifdef TAP_AUTO_RANGE_EN
        issueCmd(4'd8, 4'd1);
        check("auto_on_tap", tapStep, 10);
        check("auto_on_no_pulse", stepChanged, 0);
        issueCmd(4'd7, 4'd8);
        check("auto_set8", tapStep, 8);
        tick(1100);
        overPulse();
        check("auto_dn7", tapStep, 7);
        tick(1100);
        overPulse();
        check("auto_dn6", tapStep, 6);
        tick(1100);
        overPulse();
        check("auto_dn5", tapStep, 5);
        tick(1100);
        overPulse();
        check("auto_dn_sat", tapStep, 5);
        check("auto_dn_sat_no_pulse", stepChanged, 0);
        check("auto_dn_sat_no_busy", stepBusy, 0);

        underDec = 1'b1;
        tick(4097);
        check("under_before_hold", tapStep, 5);
        tick(1);
        check("under_up", tapStep, 6);
        check("under_up_changed", stepChanged, 1);
        underDec = 1'b0;
        tick(1100);
        underDec = 1'b1;
        tick(4000);
        underDec = 1'b0;
        tick(300);
        check("under_dropped", tapStep, 6);
        underDec = 1'b1;
        tick(4097);
        check("under_cleared_before", tapStep, 6);
        tick(1);
        check("under_cleared_up", tapStep, 7);
        underDec = 1'b0;
`else
        issueCmd(4'd8, 4'd1);
        check("op8_ignored_tap", tapStep, 10);
        check("op8_ignored_no_pulse", stepChanged, 0);
        overPulse();
        check("over_still_min", tapStep, 5);
        tick(1100);
        underDec = 1'b1;
        tick(4200);
        check("under_unused", tapStep, 5);
        underDec = 1'b0;
`endif
        tick(1100);

        // command and over-range edge in the same cycle
        inputCmd        = {4'd7, 24'h0, 4'd9};
        inputCmdTrigger = 1'b1;
        overDec         = 1'b1;
        tick(1);
        inputCmdTrigger = 1'b0;
        overDec         = 1'b0;
        tick(2);
        check("coincide_cmd_wins", tapStep, 9);
        check("coincide_busy", stepBusy, 1);

        // asynchronous reset in the middle of settle
        tick(100);
        #2;
        rest = 1'b0;
        #1;
        check("async_rst_tap", tapStep, 5);
        check("async_rst_busy", stepBusy, 0);
        check("async_rst_changed", stepChanged, 0);
        @(negedge clk);
        rest = 1'b1;
        tick(2);
        check("after_rst_tap", tapStep, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tap_step_ranger.md
# tap_step_ranger

Parametrised tap-step (gain range) controller for the pulse-measurement front end. It drives the tap-step code from three sources: host command words on the 32-bit command bus, the over-range detector and, optionally, an under-range detector for automatic up-ranging. It replaces the single-clock-domain-unsafe max/min toggler with a fully synchronous, multi-level, clamped stepper that has a post-change settle window. It sits between the command decoder and the analog tap-select outputs.

## Interface
- STEP_W, 4, width of tap-step code
- STEP_MIN, 5, lowest legal code (least gain)
- STEP_MAX, 10, highest legal code; must satisfy STEP_MIN <= STEP_MAX < 2^STEP_W
- SETTLE_CYC, 1024, cycles during which over/under inputs are ignored after any step change (>= 1)
- UNDER_HOLD, 4096, cycles underDec must stay high before an up-step (>= 1)
- clk  in  1  system clock; single clock domain
- rest  in  1  reset, asynchronous, active-low
- inputCmd  in  32  command word; [31:28] opcode, [STEP_W-1:0] argument
- inputCmdTrigger  in  1  command strobe; its rising edge executes inputCmd
- overDec  in  1  over-range flag from the level detector
- underDec  in  1  under-range flag (used only with TAP_AUTO_RANGE_EN)
- tapStep  out  STEP_W  current tap-step code
- stepChanged  out  1  one-cycle pulse on every change of tapStep
- stepBusy  out  1  high while in the settle window

## Operation
- Reset values: tapStep = STEP_MIN, stepChanged = 0, stepBusy = 0, autoMode = 0, all counters = 0, edge registers = 0.
- inputCmdTrigger, overDec and underDec each pass through one register stage. Rising edges are detected against a second register stage. inputCmd is captured together with the trigger.
- Opcodes:
  - 6: tapStep <= STEP_MAX.
  - 7: tapStep <= clamp(arg, STEP_MIN, STEP_MAX).
  - 8: autoMode <= inputCmd[0].
  - Any other opcode: ignored.
- Over-range rising edge:
  - autoMode = 0: tapStep <= STEP_MIN.
  - autoMode = 1: tapStep <= tapStep-1, saturating at STEP_MIN.
- Under-range (autoMode = 1 only): a hold counter increments while the registered underDec = 1 and clears when it is 0. On reaching UNDER_HOLD, tapStep <= tapStep+1 (saturating at STEP_MAX) and the counter clears.
- State machine:
  - MONITOR: over/under events accepted.
  - SETTLE: entered whenever tapStep actually changes. The settle counter counts SETTLE_CYC cycles, then returns to MONITOR. Over/under edges and the hold counter are ignored and held at 0 while in SETTLE.
- Commands are accepted in both states. A command that changes tapStep restarts SETTLE.
- Priority when events coincide in one cycle: command > over-range > under-range.
- A requested value equal to the current tapStep is a no-op: no stepChanged pulse and no SETTLE entry. This includes saturation at a limit.
- Arithmetic: step ±1 is computed in STEP_W+1 bits, then clamped. Counters are $clog2(max(SETTLE_CYC, UNDER_HOLD))+1 bits wide and never wrap.

## Timing
- Command, over-range edge: the input is first sampled high at edge k; tapStep and stepChanged update at edge k+2.
- Under-range: an up-step occurs at the edge on which the hold count reaches UNDER_HOLD. That is UNDER_HOLD+1 edges after underDec is first sampled high.
- stepBusy rises together with the tapStep change and falls exactly SETTLE_CYC cycles later.
- A held trigger or held overDec acts only once per rising edge.
- Asserting rest mid-settle or mid-hold returns all registers to their reset values immediately (asynchronously).

## Configuration
- TAP_AUTO_RANGE_EN defined: opcode 8, autoMode, the under-range hold counter and auto ±1 stepping are compiled in.
- Not defined: autoMode is tied to 0, opcode 8 is ignored and underDec is unused. Behaviour reduces to: opcode 6 → STEP_MAX, opcode 7 → set, over-range → STEP_MIN, with the settle window retained.

## Structure
- Shared package tap_step_pkg holds:
  - opcode constants OPC_TAP_MAX = 4'd6, OPC_TAP_SET = 4'd7, OPC_TAP_AUTO = 4'd8;
  - the state typedef {MONITOR, SETTLE}.
- One sub-module, tap_edge_sync: two-stage register plus rising-edge pulse. It is instantiated for the trigger, overDec and underDec paths.

## Test plan
- Reset, then opcode 6 strobe → tapStep 5→10 two edges after the strobe; stepChanged pulses 1 cycle; stepBusy high 1024 cycles.
- Opcode 7, arg 3 → tapStep clamps to 5. Then arg 12 → 10. Then arg 10 again → no stepChanged pulse.
- autoMode = 0, tapStep = 10, overDec pulse → tapStep = 5. A second overDec pulse inside SETTLE → ignored.
- autoMode = 1, tapStep = 8: overDec edges spaced > SETTLE_CYC → 7, 6, 5, 5 (no pulse at saturation).
- autoMode = 1: underDec held 4096 cycles → +1. underDec dropped at cycle 4000 → no step, counter clears.
- Command trigger and overDec edge in the same cycle → command wins. rest asserted mid-SETTLE → tapStep = 5, stepBusy = 0 immediately.
